// File: rtl/wr_dt_ctrl.sv
// wr_dt_ctrl: store-path controller for SB/SH/SW.
// SW is written directly. SB/SH do a read-modify-write: read the word,
// splice the byte or halfword lane in, then write the word back.
// Misaligned or unsupported stores raise a one-cycle misalign pulse.
// All outputs come straight from flops.
module wr_dt_ctrl #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         memWr,
    input  logic [2:0]   funct,
    input  logic [N-1:0] addr,
    input  logic [N-1:0] dt_in,
    output logic         busy,
    output logic         done,
    output logic         misalign,
    output logic [N-1:0] mem_addr,
    output logic         mem_rd,
    input  logic [N-1:0] mem_rdata,
    output logic         mem_wr,
    output logic [N-1:0] mem_wdata
);

    localparam logic [2:0] F_SB = 3'b000;
    localparam logic [2:0] F_SH = 3'b001;
    localparam logic [2:0] F_SW = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        MRG,
        WR,
        ERR
    } state_t;

    state_t       state;
    logic [1:0]   lane_q;   // byte offset of the store inside the word
    logic         half_q;   // 1: halfword store, 0: byte store
    logic [15:0]  data_q;   // low half of the store data (SB/SH only)

    logic         illegal;
    logic [N-1:0] merged;

    // Decode whether the presented request is unsupported or misaligned
    always_comb begin
        illegal = 1'b0;
        case (funct)
            F_SB:    illegal = 1'b0;
            F_SH:    illegal = addr[0];
            F_SW:    illegal = (addr[1:0] != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    // Splice the captured byte/halfword into the word returned by memory
    always_comb begin
        merged = mem_rdata;
        if (half_q) begin
            if (lane_q[1]) merged[31:16] = data_q;
            else           merged[15:0]  = data_q;
        end else begin
            case (lane_q)
                2'd0:    merged[7:0]   = data_q[7:0];
                2'd1:    merged[15:8]  = data_q[7:0];
                2'd2:    merged[23:16] = data_q[7:0];
                default: merged[31:24] = data_q[7:0];
            endcase
        end
    end

    // Control FSM; every output is registered alongside the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lane_q    <= '0;
            half_q    <= 1'b0;
            data_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            misalign  <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            // strobes are single-cycle pulses unless re-armed below
            done     <= 1'b0;
            misalign <= 1'b0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            case (state)
                IDLE: begin
                    if (memWr) begin
                        lane_q <= addr[1:0];
                        half_q <= (funct == F_SH);
                        data_q <= dt_in[15:0];
                        busy   <= 1'b1;
                        if (illegal) begin
                            state    <= ERR;
                            misalign <= 1'b1;
                        end else begin
                            mem_addr <= {addr[N-1:2], 2'b00};
                            if (funct == F_SW) begin
                                state     <= WR;
                                mem_wr    <= 1'b1;
                                done      <= 1'b1;
                                mem_wdata <= dt_in;
                            end else begin
                                state  <= RD;
                                mem_rd <= 1'b1;
                            end
                        end
                    end
                end
                RD: begin
                    state <= MRG;
                end
                MRG: begin
                    state     <= WR;
                    mem_wdata <= merged;
                    mem_wr    <= 1'b1;
                    done      <= 1'b1;
                end
                WR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wr_dt_ctrl.sv
// Scoreboard bench for wr_dt_ctrl: stimulus pushes expected memory events,
// a negedge monitor pops and compares whenever the DUT shows activity.
module tb_wr_dt_ctrl;

    localparam int N = 32;
    localparam int K_RD  = 0;
    localparam int K_WR  = 1;
    localparam int K_ERR = 2;
    localparam int M_SW  = 0;
    localparam int M_RMW = 1;
    localparam int M_ERR = 2;
    localparam logic [31:0] RD_WORD = 32'h11223344;

    logic         clk;
    logic         rst;
    logic         memWr;
    logic [2:0]   funct;
    logic [N-1:0] addr;
    logic [N-1:0] dt_in;
    logic         busy;
    logic         done;
    logic         misalign;
    logic [N-1:0] mem_addr;
    logic         mem_rd;
    logic [N-1:0] mem_rdata;
    logic         mem_wr;
    logic [N-1:0] mem_wdata;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] wdata;
    } ev_t;

    ev_t sb[$];
    ev_t ev;
    int  n_chk  = 0;
    int  n_fail = 0;
    int  cyc    = 0;

    wr_dt_ctrl #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .memWr     (memWr),
        .funct     (funct),
        .addr      (addr),
        .dt_in     (dt_in),
        .busy      (busy),
        .done      (done),
        .misalign  (misalign),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // memory model: read data valid only in the cycle after mem_rd
    initial mem_rdata = 32'hBAD0BAD0;
    always @(posedge clk) mem_rdata <= mem_rd ? RD_WORD : 32'hBAD0BAD0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input logic [31:0] a, input logic [31:0] w);
        ev_t e;
        e.kind = kind; e.cyc = c; e.addr = a; e.wdata = w;
        sb.push_back(e);
    endtask

    // monitor: any strobe is an event that must match the scoreboard head
    always @(negedge clk) begin
        if (!rst && (mem_rd || mem_wr || misalign || done)) begin
            chk("rd_wr_exclusive", {31'b0, mem_rd & mem_wr}, 32'd0);
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_event: got rd=%b wr=%b mis=%b done=%b addr=%h expected no activity (cycle %0d)",
                         mem_rd, mem_wr, misalign, done, mem_addr, cyc);
            end else begin
                ev = sb.pop_front();
                chk("event_cycle", cyc, ev.cyc);
                chk("busy_in_event", {31'b0, busy}, 32'd1);
                case (ev.kind)
                    K_RD:    chk("strobes_rd",  {28'b0, mem_rd, mem_wr, misalign, done}, 32'b1000);
                    K_WR:    chk("strobes_wr",  {28'b0, mem_rd, mem_wr, misalign, done}, 32'b0101);
                    default: chk("strobes_err", {28'b0, mem_rd, mem_wr, misalign, done}, 32'b0010);
                endcase
                if (ev.kind != K_ERR) chk("mem_addr", mem_addr, ev.addr);
                if (ev.kind == K_WR)  chk("mem_wdata", mem_wdata, ev.wdata);
            end
        end
    end

    task automatic wait_idle(input int k, input int len);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL busy_timeout: got busy=1 expected 0 within 12 cycles");
        end else begin
            chk("busy_len", cyc - k, len);
        end
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                         input int mode, input logic [31:0] ea, input logic [31:0] ew);
        int k;
        @(negedge clk);
        memWr = 1'b1; funct = f; addr = a; dt_in = d;
        @(posedge clk);
        #1;
        k = cyc;
        memWr = 1'b0;
        if (mode == M_SW) begin
            push(K_WR, k, ea, ew);
            wait_idle(k, 1);
        end else if (mode == M_RMW) begin
            push(K_RD, k, ea, 32'h0);
            push(K_WR, k + 2, ea, ew);
            wait_idle(k, 3);
        end else begin
            push(K_ERR, k, 32'h0, 32'h0);
            wait_idle(k, 1);
        end
    endtask

    task automatic chk_zero();
        chk("rst_busy",      {31'b0, busy},     32'd0);
        chk("rst_done",      {31'b0, done},     32'd0);
        chk("rst_misalign",  {31'b0, misalign}, 32'd0);
        chk("rst_mem_rd",    {31'b0, mem_rd},   32'd0);
        chk("rst_mem_wr",    {31'b0, mem_wr},   32'd0);
        chk("rst_mem_addr",  mem_addr,          32'd0);
        chk("rst_mem_wdata", mem_wdata,         32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        rst = 1'b0; memWr = 1'b0; funct = 3'b000; addr = '0; dt_in = '0;
        #1 rst = 1'b1;
        #2 chk_zero();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // legal stores
        do_op(3'b010, 32'h100, 32'hDEADBEEF, M_SW,  32'h100, 32'hDEADBEEF);
        do_op(3'b000, 32'h103, 32'h000000AA, M_RMW, 32'h100, 32'hAA223344);
        do_op(3'b001, 32'h202, 32'h0000BEEF, M_RMW, 32'h200, 32'hBEEF3344);
        do_op(3'b000, 32'h100, 32'hFFFFFF77, M_RMW, 32'h100, 32'h11223377);
        do_op(3'b000, 32'h102, 32'h000000CC, M_RMW, 32'h100, 32'h11CC3344);
        do_op(3'b000, 32'h101, 32'h000000EE, M_RMW, 32'h100, 32'h1122EE44);
        do_op(3'b001, 32'h200, 32'hABCD1234, M_RMW, 32'h200, 32'h11221234);
        do_op(3'b010, 32'h104, 32'h0BADF00D, M_SW,  32'h104, 32'h0BADF00D);

        // illegal stores
        do_op(3'b001, 32'h201, 32'h0, M_ERR, 32'h0, 32'h0);
        do_op(3'b010, 32'h102, 32'h0, M_ERR, 32'h0, 32'h0);
        do_op(3'b010, 32'h101, 32'h0, M_ERR, 32'h0, 32'h0);
        do_op(3'b011, 32'h100, 32'h0, M_ERR, 32'h0, 32'h0);
        do_op(3'b111, 32'h100, 32'h0, M_ERR, 32'h0, 32'h0);

        // error followed immediately by a store: request seen in ERR is ignored
        @(negedge clk);
        memWr = 1'b1; funct = 3'b011; addr = 32'h100; dt_in = 32'h0;
        @(posedge clk);
        #1 k = cyc;
        push(K_ERR, k, 32'h0, 32'h0);
        push(K_WR, k + 2, 32'h400, 32'hCAFEF00D);
        @(negedge clk);
        funct = 3'b010; addr = 32'h400; dt_in = 32'hCAFEF00D;
        @(posedge clk);
        @(posedge clk);
        #1 memWr = 1'b0;
        wait_idle(k + 2, 1);

        // memWr held through an SB while addr wanders; next accept follows WR
        @(negedge clk);
        memWr = 1'b1; funct = 3'b000; addr = 32'h103; dt_in = 32'h12345655;
        @(posedge clk);
        #1 k = cyc;
        push(K_RD, k,     32'h100, 32'h0);
        push(K_WR, k + 2, 32'h100, 32'h55223344);
        push(K_RD, k + 4, 32'h304, 32'h0);
        push(K_WR, k + 6, 32'h304, 32'h11225544);
        @(negedge clk) addr = 32'h201;
        @(negedge clk) addr = 32'h202;
        @(negedge clk) addr = 32'h206;
        @(negedge clk) addr = 32'h305;
        @(negedge clk) memWr = 1'b0;
        wait_idle(k + 4, 3);

        // reset pulsed in MRG aborts the SB, then a plain SW follows
        @(negedge clk);
        memWr = 1'b1; funct = 3'b000; addr = 32'h301; dt_in = 32'h00000099;
        @(posedge clk);
        #1 k = cyc;
        memWr = 1'b0;
        push(K_RD, k, 32'h300, 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_zero();
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        do_op(3'b010, 32'h0, 32'h1, M_SW, 32'h0, 32'h1);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
